alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences the H4 ALU datapath from a command stream.
- Accepts one {op, A, B} command per valid/ready handshake and decodes op into the H4 control word (x, y, z, u, v).
- Drives the A/B buses, holds them stable for a programmable settle time, then gates ALS_H4 and captures result and flags into a response register.
- Sits between the board interface or a future microsequencer and the H4 ALU instance.

Parameters:
- WIDTH, 16, data bus width for A, B and result.
- SETTLE_CYCLES, 2, cycles the operands and control are held before capture; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  op: 0 ADD, 1 INC, 2 SUB, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- alu_x, alu_y, alu_z, alu_u, alu_v  out  1 each  H4 control word
- alu_als  out  1  ALS_H4 gate (H4 drives S-bus)
- alu_a_bus  out  WIDTH  to H4 A_bus_in
- alu_b_bus  out  WIDTH  to H4 B_bus_in
- alu_result  in  WIDTH  from H4 ALU_result_bus
- alu_carry  in  1  from H4 carry
- alu_overflow  in  1  from H4 overflow
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WIDTH  captured result
- rsp_carry  out  1  captured carry
- rsp_overflow  out  1  captured overflow
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE.
  - All alu_* control outputs, alu_als, alu_a_bus and alu_b_bus = 0.
  - rsp_valid = 0; rsp_result, rsp_carry, rsp_overflow = 0.
  - busy = 0; cmd_ready = 1.
- Decode, registered on accept:
  - op0 → 01001, op1 → 01011, op2 → 11011, op3 → 11001.
  - op4 → 00000, op5 → 00100, op6 → 00001, op7 → 10001.
  - Bit order is x y z u v.
  - op7 (NOT) forces alu_a_bus = 0 regardless of cmd_a.
- FSM:
  - IDLE: cmd_ready = 1. On cmd_valid, latch op/a/b, drive the buses and control word next cycle, load settle counter = SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: control word and buses held constant; alu_als = 0. Counter decrements each cycle. At 0, go to CAPTURE.
  - CAPTURE (exactly 1 cycle): alu_als = 1. Register alu_result/alu_carry/alu_overflow into rsp_*, set rsp_valid = 1, go to RESP.
  - RESP: alu_als = 0, buses and control word return to 0. Hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready, clear rsp_valid; if cmd_valid is present in the same cycle, accept it directly (back-to-back, go to SETTLE), else go to IDLE.
- cmd_ready:
  - 1 in IDLE.
  - 1 in RESP only when rsp_ready = 1 (combinational on rsp_ready).
  - 0 otherwise.
- Latency: accept at cycle T → rsp_valid first high at T+SETTLE_CYCLES+2.
- Throughput: one op per SETTLE_CYCLES+2 cycles with rsp_ready held high.
- Backpressure: rsp_valid held indefinitely, no response is dropped, no new command is accepted until the response is taken.
- cmd_valid while busy is ignored (not latched).
- Reset asserted mid-operation: immediate return to the reset values; in-flight command and response are discarded.
- SETTLE_CYCLES = 1: SETTLE lasts one cycle.

Optional Feature:
- Macro: ALU_SEQ_STICKY_FLAGS_EN.
- When defined:
  - Adds input flags_clr (1) and outputs sticky_carry (1) and sticky_overflow (1).
  - Each output is the OR of the corresponding flag over every CAPTURE since reset or the last flags_clr.
  - flags_clr in the same cycle as CAPTURE takes priority: the sticky flags clear, and the captured flag is not ORed in.
  - Reset value of both sticky outputs = 0.
- When undefined: ports absent, no extra state.

Decomposition:
- Package alu_seq_pkg:
  - Op code localparams OP_ADD..OP_NOT.
  - 5-bit control word typedef {x, y, z, u, v}.
  - The 8-entry decode constant.
  - FSM state enum {IDLE, SETTLE, CAPTURE, RESP}.
- Sub-module alu_op_decode: purely combinational op → control word plus force_a_zero flag. Shared with future microsequencer.

Test Plan:
- ADD, cmd_a = 0x00FF, cmd_b = 0x0001, SETTLE_CYCLES = 2, behavioural H4 model → control word 01001 during SETTLE; alu_als high for exactly one cycle; rsp_result = 0x0100, rsp_valid at T+4.
- NOT, cmd_a = 0x1234, cmd_b = 0x00F0 → alu_a_bus = 0x0000 throughout; control word 10001; rsp_result = 0xFF0F.
- Response backpressure: rsp_ready low for 10 cycles after SUB 0x0005 − 0x0007 → rsp_result = 0xFFFE held stable; cmd_ready = 0 while held; a second cmd_valid during the hold is not accepted.
- Back-to-back: rsp_ready and cmd_valid held high with ops INC 3,4 then AND 0x0F0F,0x00FF → responses 0x0008 then 0x000F; one op every 4 cycles; no IDLE cycle between them.
- Reset mid-SETTLE: rst_n low one cycle after accepting OR → all outputs reset asynchronously (before the next edge); no response is produced; cmd_ready = 1 after release.
- With ALU_SEQ_STICKY_FLAGS_EN: ADD 0xFFFF + 0x0001 (carry) then AND → sticky_carry stays 1; flags_clr pulse → 0; flags_clr coincident with a carrying CAPTURE → sticky_carry = 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the H4 ALU op sequencer: op codes, the
// x/y/z/u/v control word, the op decode table and the sequencer FSM states.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_INC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_DEC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic x;
        logic y;
        logic z;
        logic u;
        logic v;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_ZERO = 5'b00000;

    // Five bits per op, op 0 in the least significant slice.
    localparam logic [39:0] DECODE_TABLE = {
        5'b10001,  // NOT
        5'b00001,  // XOR
        5'b00100,  // OR
        5'b00000,  // AND
        5'b11001,  // DEC
        5'b11011,  // SUB
        5'b01011,  // INC
        5'b01001   // ADD
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } seq_state_t;

    function automatic ctrl_word_t decode_ctrl(input logic [2:0] op);
        return ctrl_word_t'(DECODE_TABLE[int'(op) * 5 +: 5]);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op -> H4 control word decode, plus the flag that forces the
// A bus to zero (NOT is computed by the H4 as 0 XNOR B).
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0]  op_i,
    output ctrl_word_t  ctrl_o,
    output logic        force_a_zero_o
);

    assign ctrl_o         = decode_ctrl(op_i);
    assign force_a_zero_o = (op_i == OP_NOT);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for the H4 ALU: accept {op,A,B}, drive and settle the
// buses, gate ALS_H4 for one cycle, capture result/flags into a response.
// Optional sticky carry/overflow flags: define ALU_SEQ_STICKY_FLAGS_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             alu_x,
    output logic             alu_y,
    output logic             alu_z,
    output logic             alu_u,
    output logic             alu_v,
    output logic             alu_als,
    output logic [WIDTH-1:0] alu_a_bus,
    output logic [WIDTH-1:0] alu_b_bus,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             busy
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    ,
    input  logic             flags_clr,
    output logic             sticky_carry,
    output logic             sticky_overflow
`endif
);

    localparam cnt_t SETTLE_LOAD = cnt_t'(SETTLE_CYCLES - 1);

    seq_state_t       state_q, state_d;
    cnt_t             cnt_q, cnt_d;
    ctrl_word_t       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] a_bus_q, a_bus_d;
    logic [WIDTH-1:0] b_bus_q, b_bus_d;
    logic             als_q, als_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             busy_q, busy_d;

    ctrl_word_t       dec_ctrl_s;
    logic             dec_force_a_zero_s;
    logic             cmd_accept_s;

    alu_op_decode u_decode (
        .op_i           (cmd_op),
        .ctrl_o         (dec_ctrl_s),
        .force_a_zero_o (dec_force_a_zero_s)
    );

    // Ready is combinational on rsp_ready in RESP so a response hand-off and
    // the next command accept can share one cycle.
    assign cmd_ready    = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    assign cmd_accept_s = cmd_valid && cmd_ready;

    // Next-state, operand/control load, capture and response hand-off.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ctrl_d       = ctrl_q;
        a_bus_d      = a_bus_q;
        b_bus_d      = b_bus_q;
        als_d        = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_ovf_d    = rsp_ovf_q;

        case (state_q)
            IDLE: begin
                if (cmd_accept_s) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    ctrl_d  = dec_ctrl_s;
                    a_bus_d = dec_force_a_zero_s ? {WIDTH{1'b0}} : cmd_a;
                    b_bus_d = cmd_b;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q == cnt_t'(0)) begin
                    state_d = CAPTURE;
                    als_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            CAPTURE: begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_result_d = alu_result;
                rsp_carry_d  = alu_carry;
                rsp_ovf_d    = alu_overflow;
                ctrl_d       = CTRL_ZERO;
                a_bus_d      = {WIDTH{1'b0}};
                b_bus_d      = {WIDTH{1'b0}};
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (cmd_accept_s) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                        ctrl_d  = dec_ctrl_s;
                        a_bus_d = dec_force_a_zero_s ? {WIDTH{1'b0}} : cmd_a;
                        b_bus_d = cmd_b;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                ctrl_d      = CTRL_ZERO;
                a_bus_d     = {WIDTH{1'b0}};
                b_bus_d     = {WIDTH{1'b0}};
                rsp_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= cnt_t'(0);
            ctrl_q       <= CTRL_ZERO;
            a_bus_q      <= {WIDTH{1'b0}};
            b_bus_q      <= {WIDTH{1'b0}};
            als_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= {WIDTH{1'b0}};
            rsp_carry_q  <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ctrl_q       <= ctrl_d;
            a_bus_q      <= a_bus_d;
            b_bus_q      <= b_bus_d;
            als_q        <= als_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_ovf_q    <= rsp_ovf_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_x        = ctrl_q.x;
    assign alu_y        = ctrl_q.y;
    assign alu_z        = ctrl_q.z;
    assign alu_u        = ctrl_q.u;
    assign alu_v        = ctrl_q.v;
    assign alu_als      = als_q;
    assign alu_a_bus    = a_bus_q;
    assign alu_b_bus    = b_bus_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_ovf_q;
    assign busy         = busy_q;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic sticky_carry_q, sticky_carry_d;
    logic sticky_ovf_q, sticky_ovf_d;

    // Clear wins over a coincident capture; otherwise OR in captured flags.
    always_comb begin
        sticky_carry_d = sticky_carry_q;
        sticky_ovf_d   = sticky_ovf_q;
        if (flags_clr) begin
            sticky_carry_d = 1'b0;
            sticky_ovf_d   = 1'b0;
        end else if (state_q == CAPTURE) begin
            sticky_carry_d = sticky_carry_q | alu_carry;
            sticky_ovf_d   = sticky_ovf_q | alu_overflow;
        end else begin
            sticky_carry_d = sticky_carry_q;
            sticky_ovf_d   = sticky_ovf_q;
        end
    end

    // Sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_carry_q <= 1'b0;
            sticky_ovf_q   <= 1'b0;
        end else begin
            sticky_carry_q <= sticky_carry_d;
            sticky_ovf_q   <= sticky_ovf_d;
        end
    end

    assign sticky_carry    = sticky_carry_q;
    assign sticky_overflow = sticky_ovf_q;
`endif

endmodule
